// File: rtl/xor_descr_pkg.sv
// Shared definitions for the XOR LFSR scrambler/descrambler pair.
// Holds the default polynomial and seed, the FSM states and the Galois word-step function.
package xor_descr_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam logic [DEF_WIDTH-1:0] DEF_POLY  = 16'hB400;
  localparam logic [DEF_WIDTH-1:0] DEF_SEED0 = 16'h0001;

  typedef enum logic {
    ST_UNSEEDED = 1'b0,
    ST_RUN      = 1'b1
  } state_e;

  // One keystream word-step: DEF_WIDTH serial right-shifting Galois shifts.
  function automatic logic [DEF_WIDTH-1:0] lfsr_word_step(
    input logic [DEF_WIDTH-1:0] s,
    input logic [DEF_WIDTH-1:0] poly
  );
    logic [DEF_WIDTH-1:0] r;
    r = s;
    for (int unsigned i = 0; i < DEF_WIDTH; i++) begin
      if (r[0]) r = (r >> 1) ^ poly;
      else      r = r >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/xor_lfsr_step.sv
// Combinational WIDTH-shift Galois LFSR advance (one keystream word-step).
module xor_lfsr_step
  import xor_descr_pkg::*;
#(
  parameter int unsigned          WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0]     POLY  = DEF_POLY
) (
  input  logic [WIDTH-1:0] i_state,
  output logic [WIDTH-1:0] o_next
);

  // The shared package function covers the default width; other widths unroll locally.
  if (WIDTH == DEF_WIDTH) begin : g_pkg
    assign o_next = lfsr_word_step(i_state, POLY);
  end else begin : g_gen
    always_comb begin
      o_next = i_state;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (o_next[0]) o_next = (o_next >> 1) ^ POLY;
        else           o_next = o_next >> 1;
      end
    end
  end

endmodule

// File: rtl/xor_lfsr_descrambler.sv
// Receive-side XOR descrambler: out_data = in_data ^ keystream, one registered output stage.
// Optional accepted-word counter port word_cnt is built only with XOR_DESCR_WORD_CNT_EN.
module xor_lfsr_descrambler
  import xor_descr_pkg::*;
#(
  parameter int unsigned      WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] POLY  = DEF_POLY,
  parameter logic [WIDTH-1:0] SEED0 = DEF_SEED0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef XOR_DESCR_WORD_CNT_EN
  ,
  output logic [31:0]      word_cnt
`endif
);

  state_e           r_state;
  logic [WIDTH-1:0] r_lfsr;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [WIDTH-1:0] w_lfsr_next;
  logic             w_in_ready;
  logic             w_accept;

  xor_lfsr_step #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_step (
    .i_state (r_lfsr),
    .o_next  (w_lfsr_next)
  );

  // A reseed cycle never accepts, so the new seed is always applied before the next word.
  assign w_in_ready = (r_state == ST_RUN) && !seed_load && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && w_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_UNSEEDED;
      r_lfsr      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (seed_load) begin
        r_state <= ST_RUN;
        r_lfsr  <= (seed == '0) ? SEED0 : seed;
      end else if (w_accept) begin
        r_lfsr <= w_lfsr_next;
      end

      if (w_accept) begin
        r_out_data  <= in_data ^ r_lfsr;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef XOR_DESCR_WORD_CNT_EN
  logic [31:0] r_word_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_word_cnt <= '0;
    else if (seed_load) r_word_cnt <= '0;
    else if (w_accept)  r_word_cnt <= r_word_cnt + 32'd1;
  end

  assign word_cnt = r_word_cnt;
`endif

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_xor_lfsr_descrambler.sv
// Self-checking bench for xor_lfsr_descrambler against a behavioural keystream model.
// Also checks word_cnt when built with XOR_DESCR_WORD_CNT_EN.
module tb_xor_lfsr_descrambler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        seed_load;
  logic [15:0] seed;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
`ifdef XOR_DESCR_WORD_CNT_EN
  logic [31:0] word_cnt;
`endif

  always #5 clk = ~clk;

  xor_lfsr_descrambler #(
    .WIDTH (16),
    .POLY  (16'hB400),
    .SEED0 (16'h0001)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_load (seed_load),
    .seed      (seed),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef XOR_DESCR_WORD_CNT_EN
    ,
    .word_cnt  (word_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Model: seeded flag, keystream state, pending output word, accepted count.
  bit          m_run;
  logic [15:0] m_ks;
  bit          m_ov;
  logic [15:0] m_od;
  logic [31:0] m_cnt;

  function automatic logic [15:0] ks_adv(input logic [15:0] s);
    logic [15:0] r;
    r = s;
    repeat (16) r = r[0] ? ((r >> 1) ^ 16'hB400) : (r >> 1);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0;
    m_ks  = '0;
    m_ov  = 1'b0;
    m_od  = '0;
    m_cnt = '0;
  endtask

  // One clock cycle: called at a negedge, drives inputs, checks in_ready, then outputs after the edge.
  task automatic cyc(input bit sl, input logic [15:0] sd, input bit iv,
                     input logic [15:0] id, input bit ordy);
    bit er, acc;
    logic [15:0] old;
    seed_load = sl;
    seed      = sd;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #1;
    er  = m_run && !sl && (!m_ov || ordy);
    chk("in_ready", {31'd0, in_ready}, {31'd0, er});
    acc = iv && er;
    old = m_ks;
    if (sl) begin
      m_run = 1'b1;
      m_ks  = (sd == 16'h0000) ? 16'h0001 : sd;
      m_cnt = '0;
    end else if (acc) begin
      m_ks  = ks_adv(old);
      m_cnt = m_cnt + 32'd1;
    end
    if (acc) begin
      m_od = id ^ old;
      m_ov = 1'b1;
    end else if (ordy) begin
      m_ov = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    if (m_ov) chk("out_data", {16'd0, out_data}, {16'd0, m_od});
`ifdef XOR_DESCR_WORD_CNT_EN
    chk("word_cnt", word_cnt, m_cnt);
`endif
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] p;
    rst_n     = 1'b0;
    seed_load = 1'b0;
    seed      = '0;
    in_valid  = 1'b1;
    in_data   = 16'h1234;
    out_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
`ifdef XOR_DESCR_WORD_CNT_EN
    chk("rst_word_cnt", word_cnt, 32'd0);
`endif
    rst_n = 1'b1;

    // Unseeded: input ignored
    repeat (3) cyc(1'b0, 16'h0, 1'b1, 16'h1234, 1'b1);

    // Seed, then three back-to-back words
    cyc(1'b1, 16'hACE1, 1'b0, 16'h0, 1'b1);
    cyc(1'b0, 16'h0, 1'b1, 16'hAAAA, 1'b1);
    chk("first_word_lit", {16'd0, out_data}, 32'h064B);
    cyc(1'b0, 16'h0, 1'b1, 16'h0F0F, 1'b1);
    cyc(1'b0, 16'h0, 1'b1, 16'h9AB0, 1'b1);

    // Backpressure with a word pending
    cyc(1'b0, 16'h0, 1'b1, 16'h5555, 1'b1);
    p = out_data;
    repeat (4) cyc(1'b0, 16'h0, 1'b1, 16'h7777, 1'b0);
    chk("stall_hold", {16'd0, out_data}, {16'd0, p});
    cyc(1'b0, 16'h0, 1'b1, 16'h7777, 1'b1);

    // Zero seed substitutes 0x0001
    cyc(1'b1, 16'h0000, 1'b0, 16'h0, 1'b1);
    cyc(1'b0, 16'h0, 1'b1, 16'h00FF, 1'b1);
    chk("zero_seed_lit", {16'd0, out_data}, 32'h00FE);

    // Reseed while a word is pending
    cyc(1'b0, 16'h0, 1'b1, 16'h1111, 1'b0);
    cyc(1'b1, 16'hBEEF, 1'b1, 16'h2222, 1'b0);
    chk("reseed_pending_lit", {16'd0, out_data}, 32'h00FE);
    cyc(1'b0, 16'h0, 1'b1, 16'h3333, 1'b1);
    chk("reseed_new_lit", {16'd0, out_data}, 32'h8DDC);

    // Round trip: scramble payloads with the model keystream, expect payloads back
    for (int i = 0; i < 8; i++) begin
      p = 16'($urandom);
      cyc(1'b0, 16'h0, 1'b1, p ^ m_ks, 1'b1);
      chk("roundtrip", {16'd0, out_data}, {16'd0, p});
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 24) == 0),
          ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom),
          1'($urandom_range(0, 1)), 16'($urandom),
          ($urandom_range(0, 3) != 0));
    end

    // Async reset with a word pending
    cyc(1'b1, 16'h4321, 1'b0, 16'h0, 1'b1);
    cyc(1'b0, 16'h0, 1'b1, 16'hC0DE, 1'b0);
    chk("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_data", {16'd0, out_data}, 32'd0);
    chk("async_rst_ready", {31'd0, in_ready}, 32'd0);
`ifdef XOR_DESCR_WORD_CNT_EN
    chk("async_rst_cnt", word_cnt, 32'd0);
`endif
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) cyc(1'b0, 16'h0, 1'b1, 16'hFFFF, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
